// File: rtl/servant_ram_arbiter.sv
// Two-master, one-slave Wishbone arbiter in front of servant_ram.
// One grant per transfer, combinational ack/rdt return, optional timeout abort with an error pulse.
module servant_ram_arbiter #(
    parameter int AW       = 32,
    parameter int PRIORITY = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic [AW-1:0] i_wb_m0_adr,
    input  logic [31:0]   i_wb_m0_dat,
    input  logic [3:0]    i_wb_m0_sel,
    input  logic          i_wb_m0_we,
    input  logic          i_wb_m0_cyc,
    output logic [31:0]   o_wb_m0_rdt,
    output logic          o_wb_m0_ack,
    output logic          o_wb_m0_err,

    input  logic [AW-1:0] i_wb_m1_adr,
    input  logic [31:0]   i_wb_m1_dat,
    input  logic [3:0]    i_wb_m1_sel,
    input  logic          i_wb_m1_we,
    input  logic          i_wb_m1_cyc,
    output logic [31:0]   o_wb_m1_rdt,
    output logic          o_wb_m1_ack,
    output logic          o_wb_m1_err,

    output logic [AW-1:0] o_wb_s_adr,
    output logic [31:0]   o_wb_s_dat,
    output logic [3:0]    o_wb_s_sel,
    output logic          o_wb_s_we,
    output logic          o_wb_s_cyc,
    input  logic [31:0]   i_wb_s_rdt,
    input  logic          i_wb_s_ack,

    output logic          o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    // Counter stays one bit wide when the timeout is disabled so the design still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_hit;
    logic          err0, err1;

    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err0    = 1'b0;
        err1    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_wb_m0_cyc && !i_wb_m1_cyc) begin
                    state_d = GNT0;
                end else if (i_wb_m1_cyc && !i_wb_m0_cyc) begin
                    state_d = GNT1;
                end else if (i_wb_m0_cyc && i_wb_m1_cyc) begin
                    // Tie: fixed priority favours m0, round-robin favours whoever was not served last.
                    state_d = ((PRIORITY != 0) || last_q) ? GNT0 : GNT1;
                end
            end
            GNT0: begin
                if (i_wb_s_ack || !i_wb_m0_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (timeout_hit) begin
                    err0    = 1'b1;
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GNT1: begin
                if (i_wb_s_ack || !i_wb_m1_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else if (timeout_hit) begin
                    err1    = 1'b1;
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave side follows the granted master; state is reset asynchronously so s_cyc drops at once.
    always_comb begin
        o_wb_s_adr = '0;
        o_wb_s_dat = '0;
        o_wb_s_sel = '0;
        o_wb_s_we  = 1'b0;
        o_wb_s_cyc = 1'b0;
        case (state_q)
            GNT0: begin
                o_wb_s_adr = i_wb_m0_adr;
                o_wb_s_dat = i_wb_m0_dat;
                o_wb_s_sel = i_wb_m0_sel;
                o_wb_s_we  = i_wb_m0_we;
                o_wb_s_cyc = i_wb_m0_cyc;
            end
            GNT1: begin
                o_wb_s_adr = i_wb_m1_adr;
                o_wb_s_dat = i_wb_m1_dat;
                o_wb_s_sel = i_wb_m1_sel;
                o_wb_s_we  = i_wb_m1_we;
                o_wb_s_cyc = i_wb_m1_cyc;
            end
            default: ;
        endcase
    end

    assign o_wb_m0_ack = i_wb_s_ack && (state_q == GNT0);
    assign o_wb_m1_ack = i_wb_s_ack && (state_q == GNT1);
    assign o_wb_m0_err = err0;
    assign o_wb_m1_err = err1;
    assign o_wb_m0_rdt = i_wb_s_rdt;
    assign o_wb_m1_rdt = i_wb_s_rdt;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Directed bench for servant_ram_arbiter: a round-robin instance driven from a vector table and
// hand sequences, plus a fixed-priority instance fed by a registered-ack slave model.
module tb_servant_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m1_we, m0_cyc, m1_cyc;
    logic [31:0] s_rdt;
    logic        tb_ack, use_model;

    // Round-robin instance outputs
    logic [31:0] rr_m0_rdt, rr_m1_rdt, rr_s_adr, rr_s_dat;
    logic        rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err;
    logic [3:0]  rr_s_sel;
    logic        rr_s_we, rr_s_cyc, rr_busy, rr_s_ack, ack_rr;

    // Fixed-priority instance outputs
    logic [31:0] fp_m0_rdt, fp_m1_rdt, fp_s_adr, fp_s_dat;
    logic        fp_m0_ack, fp_m1_ack, fp_m0_err, fp_m1_err;
    logic [3:0]  fp_s_sel;
    logic        fp_s_we, fp_s_cyc, fp_busy, ack_fp;

    // servant_ram style slave: registered single-cycle ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_rr <= 1'b0;
            ack_fp <= 1'b0;
        end else begin
            ack_rr <= rr_s_cyc & ~ack_rr;
            ack_fp <= fp_s_cyc & ~ack_fp;
        end
    end
    assign rr_s_ack = use_model ? ack_rr : tb_ack;

    servant_ram_arbiter #(.AW(32), .PRIORITY(0), .TIMEOUT(8)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel), .i_wb_m0_we(m0_we),
        .i_wb_m0_cyc(m0_cyc), .o_wb_m0_rdt(rr_m0_rdt), .o_wb_m0_ack(rr_m0_ack), .o_wb_m0_err(rr_m0_err),
        .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel), .i_wb_m1_we(m1_we),
        .i_wb_m1_cyc(m1_cyc), .o_wb_m1_rdt(rr_m1_rdt), .o_wb_m1_ack(rr_m1_ack), .o_wb_m1_err(rr_m1_err),
        .o_wb_s_adr(rr_s_adr), .o_wb_s_dat(rr_s_dat), .o_wb_s_sel(rr_s_sel), .o_wb_s_we(rr_s_we),
        .o_wb_s_cyc(rr_s_cyc), .i_wb_s_rdt(s_rdt), .i_wb_s_ack(rr_s_ack), .o_busy(rr_busy)
    );

    servant_ram_arbiter #(.AW(32), .PRIORITY(1), .TIMEOUT(8)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel), .i_wb_m0_we(m0_we),
        .i_wb_m0_cyc(m0_cyc), .o_wb_m0_rdt(fp_m0_rdt), .o_wb_m0_ack(fp_m0_ack), .o_wb_m0_err(fp_m0_err),
        .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel), .i_wb_m1_we(m1_we),
        .i_wb_m1_cyc(m1_cyc), .o_wb_m1_rdt(fp_m1_rdt), .o_wb_m1_ack(fp_m1_ack), .o_wb_m1_err(fp_m1_err),
        .o_wb_s_adr(fp_s_adr), .o_wb_s_dat(fp_s_dat), .o_wb_s_sel(fp_s_sel), .o_wb_s_we(fp_s_we),
        .o_wb_s_cyc(fp_s_cyc), .i_wb_s_rdt(s_rdt), .i_wb_s_ack(ack_fp), .o_busy(fp_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // gnt: 0 = none, 1 = m0, 2 = m1 (selects which master's fields must appear on the slave port)
    typedef struct {
        logic       m0c;
        logic       m1c;
        logic       sack;
        logic [1:0] gnt;
        logic       a0;
        logic       a1;
        logic       scyc;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    logic [31:0] exp_adr, exp_dat;
    logic [3:0]  exp_sel;
    logic        exp_we;
    int          fp_a0, fp_a1, rr_a0, rr_a1;

    initial begin
        //            m0c m1c sack gnt a0 a1 scyc
        vec[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
        vec[2]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1};
        vec[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1};
        vec[6]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
        vec[9]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1};
        vec[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[11] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1};
        vec[12] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1};
        vec[13] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[15] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1};
        vec[16] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
        vec[17] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[18] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
        vec[19] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1};
        vec[20] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

        m0_adr = 32'h0000_0010; m0_dat = 32'hAAAA_5555; m0_sel = 4'b1111; m0_we = 1'b0;
        m1_adr = 32'h0000_0020; m1_dat = 32'h1234_5678; m1_sel = 4'b0011; m1_we = 1'b1;
        s_rdt  = 32'hCAFE_F00D;
        use_model = 1'b0;

        // Reset with requests and a stray ack present: everything must stay quiet.
        rst_n = 1'b0; m0_cyc = 1'b1; m1_cyc = 1'b1; tb_ack = 1'b1;
        #12;
        chk("reset_busy", {31'd0, rr_busy}, 32'd0);
        chk("reset_s_cyc", {31'd0, rr_s_cyc}, 32'd0);
        chk("reset_s_adr", rr_s_adr, 32'd0);
        chk("reset_acks", {30'd0, rr_m0_ack, rr_m1_ack}, 32'd0);
        chk("reset_errs", {30'd0, rr_m0_err, rr_m1_err}, 32'd0);
        m0_cyc = 1'b0; m1_cyc = 1'b0; tb_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            m0_cyc = vec[i].m0c; m1_cyc = vec[i].m1c; tb_ack = vec[i].sack;
            @(negedge clk);
            exp_adr = 32'd0; exp_dat = 32'd0; exp_sel = 4'd0; exp_we = 1'b0;
            if (vec[i].gnt == 2'd1) begin
                exp_adr = m0_adr; exp_dat = m0_dat; exp_sel = m0_sel; exp_we = m0_we;
            end else if (vec[i].gnt == 2'd2) begin
                exp_adr = m1_adr; exp_dat = m1_dat; exp_sel = m1_sel; exp_we = m1_we;
            end
            $display("row %0d: m0c=%0b m1c=%0b sack=%0b -> busy=%0b s_cyc=%0b ack0=%0b ack1=%0b s_adr=%h",
                     i, vec[i].m0c, vec[i].m1c, vec[i].sack, rr_busy, rr_s_cyc, rr_m0_ack, rr_m1_ack, rr_s_adr);
            chk($sformatf("row%0d_busy", i), {31'd0, rr_busy}, {31'd0, vec[i].gnt != 2'd0});
            chk($sformatf("row%0d_s_cyc", i), {31'd0, rr_s_cyc}, {31'd0, vec[i].scyc});
            chk($sformatf("row%0d_m0_ack", i), {31'd0, rr_m0_ack}, {31'd0, vec[i].a0});
            chk($sformatf("row%0d_m1_ack", i), {31'd0, rr_m1_ack}, {31'd0, vec[i].a1});
            chk($sformatf("row%0d_errs", i), {30'd0, rr_m0_err, rr_m1_err}, 32'd0);
            chk($sformatf("row%0d_s_adr", i), rr_s_adr, exp_adr);
            chk($sformatf("row%0d_s_dat", i), rr_s_dat, exp_dat);
            chk($sformatf("row%0d_s_sel", i), {28'd0, rr_s_sel}, {28'd0, exp_sel});
            chk($sformatf("row%0d_s_we", i), {31'd0, rr_s_we}, {31'd0, exp_we});
            if (vec[i].a0) chk($sformatf("row%0d_m0_rdt", i), rr_m0_rdt, 32'hCAFE_F00D);
            if (vec[i].a1) chk($sformatf("row%0d_m1_rdt", i), rr_m1_rdt, 32'hCAFE_F00D);
        end

        // Timeout: m0 granted, slave silent; err in the 8th granted cycle only.
        @(posedge clk); #1;
        m0_cyc = 1'b1; m1_cyc = 1'b0; tb_ack = 1'b0;
        @(negedge clk);
        chk("to_idle_before", {31'd0, rr_busy}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            $display("timeout cycle %0d: busy=%0b err0=%0b", k, rr_busy, rr_m0_err);
            chk($sformatf("to_busy_%0d", k), {31'd0, rr_busy}, 32'd1);
            chk($sformatf("to_err0_%0d", k), {31'd0, rr_m0_err}, {31'd0, k == 8});
            chk($sformatf("to_err1_%0d", k), {31'd0, rr_m1_err}, 32'd0);
        end
        @(posedge clk); #1;
        m0_cyc = 1'b0; tb_ack = 1'b1;
        @(negedge clk);
        $display("late ack: busy=%0b ack0=%0b ack1=%0b err0=%0b", rr_busy, rr_m0_ack, rr_m1_ack, rr_m0_err);
        chk("to_after_busy", {31'd0, rr_busy}, 32'd0);
        chk("late_ack_m0", {31'd0, rr_m0_ack}, 32'd0);
        chk("late_ack_m1", {31'd0, rr_m1_ack}, 32'd0);
        chk("to_after_err", {31'd0, rr_m0_err}, 32'd0);
        @(posedge clk); #1;
        tb_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Continuous contention against a registered-ack slave on both instances.
        use_model = 1'b1;
        fp_a0 = 0; fp_a1 = 0; rr_a0 = 0; rr_a1 = 0;
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            fp_a0 += int'(fp_m0_ack); fp_a1 += int'(fp_m1_ack);
            rr_a0 += int'(rr_m0_ack); rr_a1 += int'(rr_m1_ack);
            $display("contend %0d: fp ack0=%0b ack1=%0b rr ack0=%0b ack1=%0b", k, fp_m0_ack, fp_m1_ack,
                     rr_m0_ack, rr_m1_ack);
            @(posedge clk); #1;
        end
        chk("fp_m0_acks", 32'(fp_a0), 32'd4);
        chk("fp_m1_acks", 32'(fp_a1), 32'd0);
        chk("rr_m0_acks", 32'(rr_a0), 32'd2);
        chk("rr_m1_acks", 32'(rr_a1), 32'd2);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        use_model = 1'b0; tb_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during a GNT1 transfer: s_cyc and busy must fall before any clock edge.
        m1_cyc = 1'b1;
        @(posedge clk); #1;
        chk("rst_gnt1_s_cyc", {31'd0, rr_s_cyc}, 32'd1);
        chk("rst_gnt1_s_adr", rr_s_adr, m1_adr);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: s_cyc=%0b busy=%0b", rr_s_cyc, rr_busy);
        chk("rst_async_s_cyc", {31'd0, rr_s_cyc}, 32'd0);
        chk("rst_async_busy", {31'd0, rr_busy}, 32'd0);
        chk("rst_async_acks", {30'd0, rr_m0_ack, rr_m1_ack}, 32'd0);
        m0_cyc = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("after reset tie: s_adr=%h s_cyc=%0b", rr_s_adr, rr_s_cyc);
        chk("rst_tie_s_adr", rr_s_adr, m0_adr);
        chk("rst_tie_s_cyc", {31'd0, rr_s_cyc}, 32'd1);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
